// File: rtl/ad9226_pkg.sv
// ad9226_pkg
//   Shared definitions for the AD9226 multi-channel capture block:
//   FSM state encoding, channel-index width helper and frame counter width.
package ad9226_pkg;

    localparam int FRAME_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_STREAM  = 2'd3
    } state_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chan_idx_w(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

endpackage

// File: rtl/ad9226_multi_capture_sample_edge_sync.sv
// sample_edge_sync
//   Brings an asynchronous clock-like signal into the clk domain through a
//   2-FF synchroniser and emits a registered one-cycle pulse per rising edge.
//   The pulse appears 3 clk cycles after the input edge.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   async_in   in   asynchronous input (e.g. ADC sample clock)
//   rise_pulse out  one-cycle pulse per synchronised rising edge
module sample_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
    end

    // NOTE: state only changes here, with non-blocking assignments; all next-state
    // logic lives in always_comb so simulation and synthesis cannot disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_pulse = rise_q;

endmodule

// File: rtl/ad9226_multi_capture.sv
// ad9226_multi_capture
//   Waits SETTLE_CYCLES after each synchronised clk_sample rising edge,
//   latches NUM_CHANNELS ADC words and streams them as channel-tagged
//   AXI-Stream beats (tuser = channel, tlast on the last channel).
//   Optional build macro ADC_CAPTURE_AVERAGE_EN: accumulate 2^AVG_LOG2
//   captures per channel and stream the truncated mean instead.
// Ports:
//   clk, rst                    system clock, async active-high reset
//   clk_sample                  ADC sample clock (asynchronous)
//   enable                      capture enable (gates new frames only)
//   data_in                     channel k at [k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]
//   m_axis_tdata/tuser/tvalid/tlast/tready   AXI-Stream master
//   eoc                         pulse after a frame's last beat is accepted
//   overflow, overflow_clr      sticky dropped-edge flag and its clear
//   frame_count                 frames emitted, wrapping
module ad9226_multi_capture
    import ad9226_pkg::*;
#(
    parameter int ADC_DATA_WIDTH  = 12,
    parameter int NUM_CHANNELS    = 4,
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int SETTLE_CYCLES   = 2,
    parameter int AVG_LOG2        = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clk_sample,
    input  logic                                   enable,
    input  logic [NUM_CHANNELS*ADC_DATA_WIDTH-1:0] data_in,
    output logic [AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [chan_idx_w(NUM_CHANNELS)-1:0]    m_axis_tuser,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    output logic                                   eoc,
    output logic                                   overflow,
    input  logic                                   overflow_clr,
    output logic [FRAME_CNT_W-1:0]                 frame_count
);

    localparam int W     = ADC_DATA_WIDTH;
    localparam int IDX_W = chan_idx_w(NUM_CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
        $error("NUM_CHANNELS must be 1..16");
    end
    if (AXIS_DATA_WIDTH < ADC_DATA_WIDTH) begin : g_bad_axis_width
        $error("AXIS_DATA_WIDTH must be >= ADC_DATA_WIDTH");
    end
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be 0..255");
    end
    if (AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_bad_avg
        $error("AVG_LOG2 must be 0..8");
    end

    logic sample_edge;

    sample_edge_sync u_sample_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (clk_sample),
        .rise_pulse (sample_edge)
    );

    state_e                 state_q, state_d;
    logic [7:0]             settle_q, settle_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   overflow_q, overflow_d;
    logic                   eoc_q, eoc_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [W-1:0]           beat_word;

`ifdef ADC_CAPTURE_AVERAGE_EN
    localparam int ACC_W     = W + AVG_LOG2;
    localparam int AVG_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [AVG_CNT_W-1:0] AVG_LAST = AVG_CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]     acc_q [NUM_CHANNELS];
    logic [ACC_W-1:0]     acc_d [NUM_CHANNELS];
    logic [AVG_CNT_W-1:0] avg_cnt_q, avg_cnt_d;
`else
    logic [W-1:0]         cap_q [NUM_CHANNELS];
    logic [W-1:0]         cap_d [NUM_CHANNELS];
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        settle_d    = settle_q;
        idx_d       = idx_q;
        eoc_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
`ifdef ADC_CAPTURE_AVERAGE_EN
        acc_d       = acc_q;
        avg_cnt_d   = avg_cnt_q;
`else
        cap_d       = cap_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (sample_edge && enable) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                // Leaving on the count of 1 keeps exactly SETTLE_CYCLES cycles in SETTLE.
                if (settle_q <= 8'd1) begin
                    state_d  = ST_CAPTURE;
                    settle_d = 8'd0;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            ST_CAPTURE: begin
                idx_d = '0;
`ifdef ADC_CAPTURE_AVERAGE_EN
                for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                    acc_d[ch] = acc_q[ch] + ACC_W'(data_in[ch*W +: W]);
                end
                if (avg_cnt_q == AVG_LAST) begin
                    state_d   = ST_STREAM;
                    avg_cnt_d = '0;
                end else begin
                    state_d   = ST_IDLE;
                    avg_cnt_d = avg_cnt_q + 1'b1;
                end
`else
                for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                    cap_d[ch] = data_in[ch*W +: W];
                end
                state_d = ST_STREAM;
`endif
            end
            ST_STREAM: begin
                if (m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        idx_d       = '0;
                        eoc_d       = 1'b1;
                        frame_cnt_d = frame_cnt_q + 32'd1;
`ifdef ADC_CAPTURE_AVERAGE_EN
                        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                            acc_d[ch] = '0;
                        end
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A set in the same cycle as a clear wins.
        if (sample_edge && enable && state_q != ST_IDLE) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settle_q    <= 8'd0;
            idx_q       <= '0;
            overflow_q  <= 1'b0;
            eoc_q       <= 1'b0;
            frame_cnt_q <= '0;
            // NOTE: the per-channel storage is reset too: it is only a handful of
            // flops, and a cleared accumulator is required before the first frame.
`ifdef ADC_CAPTURE_AVERAGE_EN
            avg_cnt_q   <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) acc_q[ch] <= '0;
`else
            for (int ch = 0; ch < NUM_CHANNELS; ch++) cap_q[ch] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            idx_q       <= idx_d;
            overflow_q  <= overflow_d;
            eoc_q       <= eoc_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef ADC_CAPTURE_AVERAGE_EN
            avg_cnt_q   <= avg_cnt_d;
            acc_q       <= acc_d;
`else
            cap_q       <= cap_d;
`endif
        end
    end

`ifdef ADC_CAPTURE_AVERAGE_EN
    assign beat_word = W'(acc_q[idx_q] >> AVG_LOG2);
`else
    assign beat_word = cap_q[idx_q];
`endif

    // Outputs are decoded from registered state, so an asynchronous reset
    // drops tvalid immediately and holds tdata/tuser/tlast during a stall.
    assign m_axis_tvalid = (state_q == ST_STREAM);
    assign m_axis_tdata  = m_axis_tvalid ? AXIS_DATA_WIDTH'(beat_word) : '0;
    assign m_axis_tuser  = idx_q;
    assign m_axis_tlast  = m_axis_tvalid && (idx_q == LAST_IDX);
    assign eoc           = eoc_q;
    assign overflow      = overflow_q;
    assign frame_count   = frame_cnt_q;

endmodule
